// File: rtl/lcd_frame_reader.sv
// lcd_frame_reader: streams one IMG_W x IMG_H RGB565 frame out of a byte-wide
// buffer (high byte at even offset) as a valid/ready pixel stream with sof/eol/eof.
module lcd_frame_reader #(
    parameter int          IMG_W     = 128,
    parameter int          IMG_H     = 128,
    parameter logic [14:0] BASE_ADDR = 15'h0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        abort,
    output logic [14:0] bram_addr,
    input  logic [7:0]  bram_data,
    output logic [15:0] pix_data,
    output logic        pix_valid,
    input  logic        pix_ready,
    output logic        pix_sof,
    output logic        pix_eol,
    output logic        pix_eof,
    output logic        busy,
    output logic        frame_done
);
    localparam int CW = IMG_W > 1 ? $clog2(IMG_W) : 1;
    localparam int RW = IMG_H > 1 ? $clog2(IMG_H) : 1;
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

    typedef enum logic [2:0] {IDLE, FETCH_HI, FETCH_LO, CAPTURE, PRESENT} state_t;

    state_t        state_q, state_d;
    logic [14:0]   ptr_q, ptr_d;
    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;
    logic [7:0]    hi_q, hi_d;
    logic [15:0]   data_q, data_d;
    logic          valid_q, valid_d, sof_q, sof_d, eol_q, eol_d, eof_q, eof_d, done_q, done_d;

    assign bram_addr  = ptr_q;
    assign pix_data   = data_q;
    assign pix_valid  = valid_q;
    assign pix_sof    = sof_q;
    assign pix_eol    = eol_q;
    assign pix_eof    = eof_q;
    assign busy       = state_q != IDLE;
    assign frame_done = done_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= BASE_ADDR;
            col_q   <= '0;
            row_q   <= '0;
            hi_q    <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            sof_q   <= 1'b0;
            eol_q   <= 1'b0;
            eof_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            col_q   <= col_d;
            row_q   <= row_d;
            hi_q    <= hi_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            sof_q   <= sof_d;
            eol_q   <= eol_d;
            eof_q   <= eof_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        col_d   = col_q;
        row_d   = row_q;
        hi_d    = hi_q;
        data_d  = data_q;
        valid_d = valid_q;
        sof_d   = sof_q;
        eol_d   = eol_q;
        eof_d   = eof_q;
        done_d  = 1'b0;
        if (abort && state_q != IDLE) begin
            state_d = IDLE;
            valid_d = 1'b0;
            sof_d   = 1'b0;
            eol_d   = 1'b0;
            eof_d   = 1'b0;
        end else begin
            case (state_q)
                IDLE: if (start && !abort) begin
                    state_d = FETCH_HI;
                    ptr_d   = BASE_ADDR;
                    col_d   = '0;
                    row_d   = '0;
                end
                FETCH_HI: begin
                    ptr_d   = ptr_q + 15'd1;
                    state_d = FETCH_LO;
                end
                FETCH_LO: begin
                    hi_d    = bram_data;
                    state_d = CAPTURE;
                end
                CAPTURE: begin
                    data_d  = {hi_q, bram_data};
                    valid_d = 1'b1;
                    sof_d   = col_q == '0 && row_q == '0;
                    eol_d   = col_q == COL_LAST;
                    eof_d   = col_q == COL_LAST && row_q == ROW_LAST;
                    state_d = PRESENT;
                end
                PRESENT: if (pix_ready) begin
                    valid_d = 1'b0;
                    sof_d   = 1'b0;
                    eol_d   = 1'b0;
                    eof_d   = 1'b0;
                    if (eof_q) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        // pointer sits on the odd byte here; one step lands on the next even byte
                        ptr_d   = ptr_q + 15'd1;
                        col_d   = col_q == COL_LAST ? '0 : col_q + CW'(1);
                        row_d   = col_q == COL_LAST ? row_q + RW'(1) : row_q;
                        state_d = FETCH_HI;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_lcd_frame_reader.sv
// tb_lcd_frame_reader: directed checks of lcd_frame_reader against a 1-cycle-latency
// byte buffer model; a second instance covers address wrap at the top of memory.
module tb_lcd_frame_reader;
    logic        clk = 1'b0, rst = 1'b1, start = 1'b0, start2 = 1'b0, abort = 1'b0, pix_ready = 1'b1;
    logic [14:0] bram_addr, bram_addr2;
    logic [7:0]  bram_data, bram_data2;
    logic [15:0] pix_data, pix_data2;
    logic        pix_valid, pix_sof, pix_eol, pix_eof, busy, frame_done;
    logic        pix_valid2, pix_sof2, pix_eol2, pix_eof2, busy2, frame_done2;
    logic [7:0]  mem1 [32768];
    logic [7:0]  mem2 [32768];
    int          n_chk = 0, n_fail = 0, frames = 0;

    always #5 clk = ~clk;

    lcd_frame_reader #(.IMG_W(4), .IMG_H(2), .BASE_ADDR(15'h0100)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .bram_addr(bram_addr), .bram_data(bram_data),
        .pix_data(pix_data), .pix_valid(pix_valid), .pix_ready(pix_ready),
        .pix_sof(pix_sof), .pix_eol(pix_eol), .pix_eof(pix_eof),
        .busy(busy), .frame_done(frame_done));

    lcd_frame_reader #(.IMG_W(4), .IMG_H(1), .BASE_ADDR(15'h7FFC)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .abort(1'b0),
        .bram_addr(bram_addr2), .bram_data(bram_data2),
        .pix_data(pix_data2), .pix_valid(pix_valid2), .pix_ready(1'b1),
        .pix_sof(pix_sof2), .pix_eol(pix_eol2), .pix_eof(pix_eof2),
        .busy(busy2), .frame_done(frame_done2));

    always @(posedge clk) begin
        bram_data  <= mem1[bram_addr];
        bram_data2 <= mem2[bram_addr2];
        if (frame_done) frames <= frames + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_pix(input logic [15:0] d, input string tag);
        int n = 0;
        while (!(pix_valid === 1'b1 && pix_data === d) && n < 64) begin
            @(negedge clk);
            n++;
        end
        chk(tag, {pix_valid, pix_data}, {1'b1, d});
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (frame_done !== 1'b1 && n < 64) begin
            @(negedge clk);
            n++;
        end
        chk(tag, frame_done, 1);
    endtask

    logic [14:0] hi_tab [4] = '{15'h7FFC, 15'h7FFE, 15'h0000, 15'h0002};
    logic [14:0] lo_tab [4] = '{15'h7FFD, 15'h7FFF, 15'h0001, 15'h0003};
    logic [15:0] px_tab [4] = '{16'hFCFD, 16'hFEFF, 16'h0001, 16'h0203};

    initial begin
        for (int i = 0; i < 32768; i++) begin
            mem1[i] = 8'h00;
            mem2[i] = i[7:0];
        end
        for (int i = 0; i < 16; i++) mem1[15'h0100 + i] = i[7:0];
        repeat (2) @(negedge clk);
        chk("rst_valid", pix_valid, 0);
        chk("rst_data", pix_data, 0);
        chk("rst_flags", {pix_sof, pix_eol, pix_eof}, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", frame_done, 0);
        chk("rst_addr", bram_addr, 15'h0100);
        chk("rst_addr2", bram_addr2, 15'h7FFC);
        rst = 1'b0;
        @(negedge clk);
        // full frame, ready held high: 3-edge latency and 4-cycle pixel period
        start = 1'b1;
        for (int p = 0; p < 8; p++) begin
            repeat (3) begin
                @(negedge clk);
                start = 1'b0;
                chk("gap_valid", pix_valid, 0);
            end
            @(negedge clk);
            chk("px_valid", pix_valid, 1);
            chk("px_data", pix_data, ((2 * p) << 8) | (2 * p + 1));
            chk("px_sof", pix_sof, p == 0);
            chk("px_eol", pix_eol, p % 4 == 3);
            chk("px_eof", pix_eof, p == 7);
            chk("px_busy", busy, 1);
        end
        @(negedge clk);
        chk("done_pulse", frame_done, 1);
        chk("done_valid", pix_valid, 0);
        chk("done_busy", busy, 0);
        @(negedge clk);
        chk("done_single", frame_done, 0);
        chk("frames_1", frames, 1);
        // back-pressure: stall on pixel 2
        pix_ready = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_pix(16'h0001, "bp_px0");
        pix_ready = 1'b1;
        @(negedge clk);
        pix_ready = 1'b0;
        wait_pix(16'h0203, "bp_px1");
        pix_ready = 1'b1;
        @(negedge clk);
        pix_ready = 1'b0;
        wait_pix(16'h0405, "bp_px2");
        repeat (10) begin
            @(negedge clk);
            chk("stall_data", pix_data, 16'h0405);
            chk("stall_valid", pix_valid, 1);
            chk("stall_addr", bram_addr, 15'h0105);
        end
        pix_ready = 1'b1;
        wait_done("bp_done");
        @(negedge clk);
        chk("frames_2", frames, 2);
        // abort during pixel 5, then restart
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_pix(16'h0A0B, "ab_px5");
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("ab_busy", busy, 0);
        chk("ab_valid", pix_valid, 0);
        chk("ab_done", frame_done, 0);
        chk("ab_flags", {pix_sof, pix_eol, pix_eof}, 0);
        @(negedge clk);
        chk("ab_nodone", frame_done, 0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_pix(16'h0001, "rs_px0");
        chk("rs_sof", pix_sof, 1);
        // abort together with acceptance of the final pixel
        wait_pix(16'h0E0F, "af_px7");
        chk("af_eof", pix_eof, 1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("af_busy", busy, 0);
        chk("af_done", frame_done, 0);
        chk("af_eof_clr", pix_eof, 0);
        @(negedge clk);
        chk("af_nodone", frame_done, 0);
        chk("frames_ab", frames, 2);
        // address wrap at the top of the 15-bit space
        start2 = 1'b1;
        for (int p = 0; p < 4; p++) begin
            @(negedge clk);
            start2 = 1'b0;
            chk("wr_addr_hi", bram_addr2, hi_tab[p]);
            @(negedge clk);
            chk("wr_addr_lo", bram_addr2, lo_tab[p]);
            repeat (2) @(negedge clk);
            chk("wr_valid", pix_valid2, 1);
            chk("wr_data", pix_data2, px_tab[p]);
            chk("wr_flags", {pix_sof2, pix_eol2, pix_eof2}, {p == 0, p == 3, p == 3});
        end
        @(negedge clk);
        chk("wr_done", frame_done2, 1);
        chk("wr_busy", busy2, 0);
        // reset in FETCH_LO of pixel 3, with a start pulse ignored while busy
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_pix(16'h0405, "rr_px2");
        @(negedge clk);
        chk("rr_fetch_hi", bram_addr, 15'h0106);
        start = 1'b1;
        @(negedge clk);
        chk("rr_fetch_lo", bram_addr, 15'h0107);
        chk("rr_busy", busy, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        start = 1'b0;
        chk("rr_valid", pix_valid, 0);
        chk("rr_data", pix_data, 0);
        chk("rr_flags", {pix_sof, pix_eol, pix_eof}, 0);
        chk("rr_busy0", busy, 0);
        chk("rr_done", frame_done, 0);
        chk("rr_addr", bram_addr, 15'h0100);
        repeat (3) @(negedge clk);
        chk("rr_idle", busy, 0);
        chk("rr_frames", frames, 2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/lcd_frame_reader.md
LCD_FRAME_READER -- requirements
Module: lcd_frame_reader

Interface
REQ-001 SHALL have parameter IMG_W, default 128, meaning pixels per row.
REQ-002 SHALL have parameter IMG_H, default 128, meaning rows per frame.
REQ-003 SHALL have parameter BASE_ADDR, default 0, meaning the 15-bit byte address of the first pixel's high byte.
REQ-004 SHALL have port clk  in  1  sole clock (the read-side clock of the image buffer).
REQ-005 SHALL have port rst  in  1  reset; one clock, synchronous, active-high.
REQ-006 SHALL have port start  in  1  single-cycle request to stream one frame.
REQ-007 SHALL have port abort  in  1  terminates the current frame.
REQ-008 SHALL have port bram_addr  out  15  byte address to the buffer read port.
REQ-009 SHALL have port bram_data  in  8  buffer read data, valid 1 cycle after the address.
REQ-010 SHALL have port pix_data  out  16  RGB565 pixel.
REQ-011 SHALL have port pix_valid  out  1  pix_data valid.
REQ-012 SHALL have port pix_ready  in  1  consumer accepts the pixel.
REQ-013 SHALL have port pix_sof  out  1  qualifies pixel (0,0).
REQ-014 SHALL have port pix_eol  out  1  qualifies the last pixel of a row.
REQ-015 SHALL have port pix_eof  out  1  qualifies the last pixel of the frame.
REQ-016 SHALL have port busy  out  1  high whenever state is not IDLE.
REQ-017 SHALL have port frame_done  out  1  one-cycle pulse after the last pixel is accepted.

Function
REQ-018 SHALL implement states IDLE, FETCH_HI, FETCH_LO, CAPTURE, PRESENT.
REQ-019 SHALL drive bram_addr combinationally from a 15-bit byte pointer; pointer arithmetic wraps modulo 32768.
REQ-020 IDLE: on start=1 and abort=0, SHALL load pointer=BASE_ADDR, col=0, row=0, and go to FETCH_HI; start SHALL be ignored in every other state.
REQ-021 FETCH_HI: pointer=2n (relative to BASE_ADDR); SHALL increment pointer and go to FETCH_LO.
REQ-022 FETCH_LO: SHALL latch bram_data as the high byte and go to CAPTURE.
REQ-023 CAPTURE: SHALL register pix_data={high byte, bram_data}, set pix_valid=1 with sof/eol/eof flags, and go to PRESENT.
REQ-024 The first pix_valid SHALL assert 3 clock edges after the edge that sampled start.
REQ-025 PRESENT: pix_data, pix_valid, and the flags SHALL hold stable until pix_ready=1.
REQ-026 In PRESENT with pix_ready=1, a non-final pixel SHALL clear pix_valid, increment pointer, advance col (col wraps to 0 at IMG_W-1 and row increments), and go to FETCH_HI.
REQ-027 Minimum pixel period SHALL be 4 cycles.
REQ-028 The byte order SHALL be the high byte at the even offset and the low byte at the odd offset.
REQ-029 pix_sof SHALL be 1 only when col=0 and row=0.
REQ-030 pix_eol SHALL be 1 only when col=IMG_W-1.
REQ-031 pix_eof SHALL be 1 only when col=IMG_W-1 and row=IMG_H-1.
REQ-032 When the final pixel (pix_eof=1) is accepted, SHALL return to IDLE, clear pix_valid, and pulse frame_done for exactly 1 cycle on the following cycle.
REQ-033 abort=1 in any non-IDLE state SHALL go to IDLE at the next edge, clear pix_valid and flags, and not pulse frame_done.
REQ-034 Simultaneous abort and pix_ready on the final pixel: abort SHALL win, with no frame_done.
REQ-035 start and abort both 1 in IDLE SHALL leave the block in IDLE.
REQ-036 A start arriving in the frame_done cycle SHALL be accepted, since the state is IDLE then.
REQ-037 col SHALL be sized clog2(IMG_W) bits and row clog2(IMG_H) bits; frame span 2*IMG_W*IMG_H bytes.

Reset
REQ-038 rst=1 at an edge SHALL force IDLE, pointer=BASE_ADDR (bram_addr=BASE_ADDR), col=row=0, pix_data=0, pix_valid=0, pix_sof=pix_eol=pix_eof=0, busy=0, frame_done=0.
REQ-039 rst SHALL dominate start and abort.
REQ-040 Reset mid-frame SHALL discard the frame with no frame_done pulse.

Verification (IMG_W=4, IMG_H=2, BASE_ADDR=0x0100, buffer model with 1-cycle read latency)
REQ-041 Fill buffer bytes 0x0100..0x010F with 0x00..0x0F; start with pix_ready=1 -> pixels 0x0001,0x0203,...,0x0E0F in order, sof on pixel 0, eol on pixels 3 and 7, eof on pixel 7, frame_done 1 cycle after pixel 7 is accepted.
REQ-042 Start pulse -> pix_valid high exactly 3 edges later with pix_data=0x0001; with pix_ready held 1, consecutive pix_valid rising edges SHALL be 4 cycles apart.
REQ-043 Hold pix_ready=0 for 10 cycles on pixel 2 -> pix_data=0x0405 and pix_valid SHALL stay stable; bram_addr SHALL stay unchanged until release.
REQ-044 abort during PRESENT of pixel 5 -> IDLE next cycle, busy=0, pix_valid=0, no frame_done; a new start restarts at 0x0001 with sof=1.
REQ-045 BASE_ADDR=0x7FFC, IMG_W=4, IMG_H=1 -> bram_addr sequence 7FFC..7FFF, 0000..0003 (wrap), 4 pixels, eof on the 4th.
REQ-046 rst asserted in FETCH_LO of pixel 3 -> next cycle all outputs 0 and bram_addr=0x0100; start pulses during busy are ignored (frame count unchanged).
